// File: rtl/rf_scan_ctrl.sv
// Debug-mode register-file scanner. While debug mode is on it steps the
// second RF read port through every register at a slow rate and hands each
// captured {address, data} pair to the seven-segment display driver with a
// one-cycle valid strobe. In normal mode it sits idle with the read address
// parked at 0.
module rf_scan_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int NREG     = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sw_i,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              frame_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NREG - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              last_in_pass;

  logic dbg_en;
  logic pause;
  logic reverse;
  logic sw_unused;

  assign dbg_en    = sw_i[1];
  assign pause     = sw_i[0];
  assign reverse   = sw_i[2];
  assign sw_unused = ^sw_i[15:3];

  // Next scan address and end-of-pass flag; wrap is modulo NREG, not 2**ADDR_W.
  always_comb begin
    if (reverse) begin
      last_in_pass = (scan_addr == '0);
      next_addr    = last_in_pass ? ADDR_LAST : scan_addr - ADDR_W'(1);
    end else begin
      last_in_pass = (scan_addr == ADDR_LAST);
      next_addr    = last_in_pass ? '0 : scan_addr + ADDR_W'(1);
    end
  end

  // Scan FSM: address stepping, hold counter, capture and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      scan_addr  <= '0;
      cnt        <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt       <= '0;
          scan_addr <= '0;
          if (dbg_en) begin
            state     <= ST_SCAN;
            scan_addr <= reverse ? ADDR_LAST : '0;
          end
        end
        ST_SCAN: begin
          // Leaving debug beats pause and terminal count.
          if (!dbg_en) begin
            state     <= ST_IDLE;
            scan_addr <= '0;
            cnt       <= '0;
          end else if (pause) begin
            cnt       <= cnt;
          end else if (cnt == CNT_LAST) begin
            disp_addr  <= scan_addr;
            disp_data  <= rd_data;
            disp_valid <= 1'b1;
            frame_done <= last_in_pass;
            scan_addr  <= next_addr;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          scan_addr <= '0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
